// File: rtl/fetch_responder_if.sv
// fetch_responder_if: request/response and program-load signals between the
// fetch stage (master) and the instruction-memory responder (slave).
interface fetch_responder_if #(
    parameter int DEPTH = 256
) ();
    localparam int IDX_W = $clog2(DEPTH);

    // fetch request channel
    logic             req_valid;
    logic             req_ready;
    logic [63:0]      req_addr;

    // fetch response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_inst;
    logic [63:0]      rsp_addr;
    logic             rsp_err;

    // control and program-image load port
    logic             flush;
    logic             prog_we;
    logic [IDX_W-1:0] prog_addr;
    logic [31:0]      prog_data;

    // fetch-stage side
    modport master (
        output req_valid, req_addr, rsp_ready, flush, prog_we, prog_addr, prog_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
    );

    // responder side
    modport slave (
        input  req_valid, req_addr, rsp_ready, flush, prog_we, prog_addr, prog_data,
        output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
    );
endinterface

// File: rtl/fetch_responder.sv
// fetch_responder: instruction-memory responder for the pc fetch interface.
// Accepts one byte-addressed fetch at a time and answers with the 32-bit word
// LATENCY cycles after the accept cycle. Backpressure is given by req_ready.
// The program image is loaded through the prog_* write port at any time.
// Optional macro FETCH_MISALIGN_TRAP_EN: when defined, an address with
// req_addr[1:0] != 0 returns rsp_err=1 / rsp_inst=0; when undefined those two
// bits are ignored. Out-of-range addresses (>= DEPTH*4) always return an error.
module fetch_responder #(
    parameter  int DEPTH   = 256,
    parameter  int LATENCY = 2,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    fetch_responder_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // counter preload; the read happens on the edge where the counter sits at 1
    localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);
    // with a single-cycle latency the read is done on the accept edge itself
    localparam bit         LAT_ONE   = (LATENCY == 1);

    // instruction storage (block RAM, never reset)
    logic [31:0]      r_mem [DEPTH];
    logic [31:0]      r_rd_data;

    logic [1:0]       r_state;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic [63:0]      r_addr;
    logic [3:0]       r_count;

    logic             w_accept;
    logic             w_wait_done;
    logic             w_rd_en;
    logic             w_use_req;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_hi_nz;
    logic             w_err;

    // a request is taken only in IDLE with ready high and no flush this cycle
    assign w_accept    = (r_state == S_IDLE) && r_req_ready && bus.req_valid && !bus.flush;
    assign w_wait_done = (r_state == S_WAIT) && (r_count == 4'd1);
    assign w_rd_en     = !bus.flush && ((w_accept && LAT_ONE) || w_wait_done);

    // address source for the read: live request on the accept edge, else the captured one
    assign w_use_req = (r_state == S_IDLE);
    assign w_rd_idx  = w_use_req ? bus.req_addr[IDX_W+1:2] : r_addr[IDX_W+1:2];
    // any bit above the word-index range set means the address is past the array (no wrap)
    assign w_hi_nz   = w_use_req ? (|bus.req_addr[63:IDX_W+2]) : (|r_addr[63:IDX_W+2]);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic w_lo_nz;
    assign w_lo_nz = w_use_req ? (|bus.req_addr[1:0]) : (|r_addr[1:0]);
    assign w_err   = w_hi_nz | w_lo_nz;
`else
    assign w_err   = w_hi_nz;
`endif

    // program writes and the response read share one port-pair; read returns pre-write data
    always_ff @(posedge clk) begin
        if (bus.prog_we) begin
            r_mem[bus.prog_addr] <= bus.prog_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_idx];
        end
    end

    // control FSM: flush overrides everything except reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_addr      <= 64'd0;
            r_count     <= 4'd0;
        end else if (bus.flush) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_count     <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_req_ready) begin
                        // first edge out of reset: open for requests
                        r_req_ready <= 1'b1;
                    end else if (bus.req_valid) begin
                        r_addr      <= bus.req_addr;
                        r_req_ready <= 1'b0;
                        if (LAT_ONE) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_err;
                            r_count     <= 4'd0;
                        end else begin
                            r_state     <= S_WAIT;
                            r_count     <= LAT_M1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_count == 4'd1) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_count     <= 4'd0;
                    end else begin
                        r_count     <= r_count - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // the RAM output register is not reset, so the word is masked unless a good response is held
    assign bus.rsp_inst  = (r_rsp_valid && !r_rsp_err) ? r_rd_data : 32'd0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_addr  = r_addr;
    assign bus.req_ready = r_req_ready;

endmodule

// File: tb/tb_fetch_responder.sv
// tb_fetch_responder: directed plus randomized checks of fetch_responder against
// a word-array reference model. The model returns the array contents as they
// stood just before the read edge (accept cycle + LATENCY - 1).
module tb_fetch_responder;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int IDX_W   = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_responder_if #(.DEPTH(DEPTH)) bus ();

    fetch_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] model_mem [DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; mirror any program write that the edge commits
    task automatic tick();
        logic             we;
        logic [IDX_W-1:0] wa;
        logic [31:0]      wd;
        we = bus.prog_we;
        wa = bus.prog_addr;
        wd = bus.prog_data;
        @(posedge clk);
        #1;
        if (we) model_mem[wa] = wd;
    endtask

    task automatic write_word(input logic [IDX_W-1:0] idx, input logic [31:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = idx;
        bus.prog_data = data;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    // one full fetch: accept, latency, optional hold with rsp_ready low, handshake
    task automatic do_fetch(input logic [63:0] addr, input int hold, input int wr_edge,
                            input logic [IDX_W-1:0] wr_idx, input logic [31:0] wr_data);
        int          guard;
        logic        exp_err;
        logic [31:0] exp_inst;
        logic [63:0] a;
        guard = 0;
        bus.rsp_ready = 1'b0;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk("req_ready_before_accept", bus.req_ready, 64'd1);
        a = addr;
        exp_err = (addr >= 64'(DEPTH * 4));
`ifdef FETCH_MISALIGN_TRAP_EN
        if (a[1:0] != 2'b00) exp_err = 1'b1;
`endif
        exp_inst = 32'd0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        for (int e = 0; e < LATENCY; e++) begin
            if (e == wr_edge) begin
                bus.prog_we   = 1'b1;
                bus.prog_addr = wr_idx;
                bus.prog_data = wr_data;
            end
            if (e == LATENCY - 1) exp_inst = exp_err ? 32'd0 : model_mem[a[IDX_W+1:2]];
            tick();
            bus.prog_we   = 1'b0;
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_addr  = {$urandom, $urandom};
            bus.rsp_ready = (e == LATENCY - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            chk("req_ready_busy", bus.req_ready, 64'd0);
            chk("rsp_valid_timing", bus.rsp_valid, 64'(e == LATENCY - 1));
        end
        $display("fetch addr=%h hold=%0d wr_edge=%0d -> inst=%h err=%0b (exp inst=%h err=%0b)",
                 addr, hold, wr_edge, bus.rsp_inst, bus.rsp_err, exp_inst, exp_err);
        chk("rsp_inst", bus.rsp_inst, 64'(exp_inst));
        chk("rsp_addr", bus.rsp_addr, addr);
        chk("rsp_err", bus.rsp_err, 64'(exp_err));
        for (int h = 0; h < hold; h++) begin
            tick();
            bus.req_valid = 1'($urandom_range(0, 1));
            chk("hold_rsp_valid", bus.rsp_valid, 64'd1);
            chk("hold_rsp_inst", bus.rsp_inst, 64'(exp_inst));
            chk("hold_rsp_addr", bus.rsp_addr, addr);
            chk("hold_rsp_err", bus.rsp_err, 64'(exp_err));
            chk("hold_req_ready", bus.req_ready, 64'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", bus.rsp_valid, 64'd0);
        chk("post_hs_req_ready", bus.req_ready, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0]      a;
        logic [IDX_W-1:0] idx;
        int               r;
        int               wr_e;

        bus.req_valid = 1'b0;
        bus.req_addr  = 64'd0;
        bus.rsp_ready = 1'b0;
        bus.flush     = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = 32'd0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", bus.req_ready, 64'd0);
        chk("reset_rsp_valid", bus.rsp_valid, 64'd0);
        chk("reset_rsp_inst", bus.rsp_inst, 64'd0);
        chk("reset_rsp_addr", bus.rsp_addr, 64'd0);
        chk("reset_rsp_err", bus.rsp_err, 64'd0);
        rst_n = 1'b1;
        chk("release_req_ready_low", bus.req_ready, 64'd0);
        tick();
        chk("release_req_ready_high", bus.req_ready, 64'd1);

        // program image
        for (int i = 0; i < DEPTH; i++) write_word(IDX_W'(i), $urandom);
        write_word(8'd0, 32'h00A00293);
        write_word(8'd1, 32'h00300313);
        write_word(8'd2, 32'h0FFF0393);
        write_word(8'd3, 32'h11111111);

        // back-to-back basic fetches
        do_fetch(64'd0, 0, -1, '0, 32'd0);
        do_fetch(64'd4, 0, -1, '0, 32'd0);
        // response held for 5 cycles
        do_fetch(64'd8, 5, -1, '0, 32'd0);
        // range boundaries
        do_fetch(64'h3FC, 1, -1, '0, 32'd0);
        do_fetch(64'h400, 1, -1, '0, 32'd0);
        do_fetch(64'h8000_0000_0000_0000, 0, -1, '0, 32'd0);
        do_fetch(64'h0000_0001_0000_0004, 0, -1, '0, 32'd0);

        // flush one cycle after the accept; a same-cycle request is ignored
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'd0;
        tick();
        chk("flush_pre_rsp_valid", bus.rsp_valid, 64'd0);
        bus.flush     = 1'b1;
        bus.req_addr  = 64'd8;
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush_rsp_valid", bus.rsp_valid, 64'd0);
        chk("flush_req_ready", bus.req_ready, 64'd1);
        for (int i = 0; i < LATENCY + 1; i++) begin
            tick();
            chk("flush_no_rsp", bus.rsp_valid, 64'd0);
            chk("flush_idle_ready", bus.req_ready, 64'd1);
        end
        do_fetch(64'd4, 0, -1, '0, 32'd0);

        // flush while a response is held drops it
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'd8;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 1; i < LATENCY; i++) tick();
        chk("resp_held_valid", bus.rsp_valid, 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_resp_valid", bus.rsp_valid, 64'd0);
        chk("flush_resp_ready", bus.req_ready, 64'd1);

        // write to the pending word before the read edge, then on the read edge
        do_fetch(64'd12, 0, 0, 8'd3, 32'hDEADBEEF);
        write_word(8'd3, 32'h11111111);
        do_fetch(64'd12, 0, LATENCY - 1, 8'd3, 32'hDEADBEEF);

        // misaligned address
        do_fetch(64'd2, 0, -1, '0, 32'd0);

        // reset asserted mid-fetch discards it
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'd0;
        tick();
        bus.req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", bus.rsp_valid, 64'd0);
        chk("midreset_req_ready", bus.req_ready, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < LATENCY + 2; i++) begin
            tick();
            chk("midreset_no_rsp", bus.rsp_valid, 64'd0);
        end
        do_fetch(64'd4, 0, -1, '0, 32'd0);

        // randomized fetches with random holds and colliding writes
        for (int n = 0; n < 40; n++) begin
            r   = int'($urandom_range(0, 9));
            idx = IDX_W'($urandom_range(0, DEPTH - 1));
            if (r < 7)       a = 64'(idx) << 2;
            else if (r == 7) a = (64'(idx) << 2) | 64'($urandom_range(1, 3));
            else if (r == 8) a = {$urandom | 32'h1, $urandom};
            else             a = 64'(DEPTH * 4) + 64'($urandom_range(0, 4095));
            wr_e = int'($urandom_range(0, LATENCY)) - 1;
            if ($urandom_range(0, 1) == 0) idx = a[IDX_W+1:2];
            else idx = IDX_W'($urandom_range(0, DEPTH - 1));
            do_fetch(a, int'($urandom_range(0, 3)), wr_e, idx, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
